crossword_entry_ctrl: RTL and testbench
=======================================

// Module: crossword_entry_ctrl
// PURPOSE
//   Sequences keyboard entry into the crossword text buffer. Takes the USB HID keycode exported by the SoC
//   and maintains a grid cursor. Issues single-cell write transactions (req/ack) toward the text controller
//   port that shares the character RAM with the VGA reader. Also provides typematic auto-repeat for held keys.
// PARAMETERS
//   GRID_W       15          grid columns (cursor_x range 0..GRID_W-1)
//   GRID_H       15          grid rows (cursor_y range 0..GRID_H-1)
//   ADDR_W       8           width of wr_addr; must hold GRID_W*GRID_H-1
//   REPEAT_DLY   25_000_000  cycles a key must be held before the first repeat
//   REPEAT_RATE  5_000_000   cycles between subsequent repeats
// PORTS
//   clk_clk        in   1       system clock; all logic rising-edge
//   reset_reset_n  in   1       reset, synchronous, active-low
//   keycode        in   8       HID keycode from SoC PIO; 0x00 = no key
//   move_hl        in   1       entry direction: 1 = horizontal (advance x), 0 = vertical (advance y)
//   start_sw       in   1       entry enable; 0 = new keys ignored
//   wr_req         out  1       write request to character RAM port
//   wr_addr        out  ADDR_W  cell address = cursor_y*GRID_W + cursor_x at request time
//   wr_data        out  8       ASCII to store
//   wr_ack         in   1       port accepted the write this cycle
//   cursor_x       out  4       current column
//   cursor_y       out  4       current row
//   busy           out  1       1 whenever FSM is not in IDLE or HOLD
// BEHAVIOUR
//   Reset: state IDLE; wr_req=0, wr_addr=0, wr_data=0x20, cursor_x=0, cursor_y=0, busy=0, repeat counter=0.
//   Reset asserted mid-write drops wr_req the cycle after reset is sampled; no pending write is retained.
//   FSM: IDLE -> DECODE -> (WRITE -> MOVE | MOVE) -> HOLD -> IDLE.
//   IDLE: if start_sw=1 and keycode!=0, latch keycode into key_q, then go to DECODE.
//   DECODE: classify key_q.
//     0x04..0x1D  letter. wr_data = 0x41 + (key_q-0x04). Go to WRITE, then MOVE forward.
//     0x2A        backspace. wr_data = 0x20. Go to WRITE, then MOVE backward.
//     0x4F/0x50   right/left. Go to MOVE, x+1 / x-1.
//     0x51/0x52   down/up. Go to MOVE, y+1 / y-1.
//     Other codes go straight to HOLD with no write and no move.
//   WRITE: wr_req=1 with wr_addr/wr_data stable. Hold until wr_ack is sampled 1, then wr_req=0 next cycle and go to MOVE.
//     A pending write always completes, even if start_sw or keycode change meanwhile.
//   MOVE: forward/backward applies to x if move_hl=1, else to y (move_hl sampled in MOVE).
//     Cursor clamps at 0 and GRID_x-1; there is no wrap, and a clamped move is a silent no-op.
//   Letter-key latency: keycode new at cycle N -> wr_req=1 at N+2 (IDLE sample, DECODE).
//   HOLD: if keycode != key_q (release or different key): clear counter and go to IDLE. A different key is
//     therefore processed as a fresh press 1 cycle later. Else count; at REPEAT_DLY (first) or REPEAT_RATE
//     (subsequent), re-enter DECODE with the same key_q. start_sw=0 in HOLD suppresses repeats.
//   Simultaneous wr_ack and keycode change in WRITE: ack is honoured; the keycode change is seen in HOLD.
//   Arithmetic: address multiply-add is unsigned ADDR_W; counter width is clog2(REPEAT_DLY+1).
// STRUCTURE
//   crossword_pkg: HID keycode constants (KC_A, KC_Z, KC_BKSP, KC_RIGHT, KC_LEFT, KC_DOWN, KC_UP),
//     ASCII_SPACE, ASCII_A, GRID_W/GRID_H defaults, state enum entry_state_t.
//   Sub-module typematic_timer: counter with first/rate thresholds; inputs run and clear, output fire.
// TESTING
//   Reset: hold reset_reset_n=0 for 3 cycles -> all outputs at reset values; wr_req=0 throughout.
//   Letter: start_sw=1, move_hl=1, keycode 0x04 at cursor (0,0) -> wr_req at +2, addr 0, data 0x41;
//     ack -> cursor (1,0).
//   Clamp/vertical: cursor (3,14), move_hl=0, keycode 0x1D -> write addr 213, data 0x5A; cursor stays (3,14).
//   Backspace: cursor (5,2), move_hl=1, keycode 0x2A -> write addr 35, data 0x20; cursor becomes (4,2).
//   Ack stall: wr_ack held 0 for 10 cycles while keycode drops to 0 -> wr_req, addr, data stable;
//     one write on ack; then IDLE.
//   Repeat: REPEAT_DLY=20, REPEAT_RATE=5, hold 0x4F from (0,0) for 40 cycles -> moves at press,
//     ~+20, ~+25, ~+30, ~+35; cursor_x=5.

Source files
------------

// File: rtl/crossword_pkg.sv
`default_nettype none
// ============================================================================
// crossword_pkg : shared keycodes, ASCII constants, grid defaults and FSM types
// Revision 1.0
// ============================================================================
package crossword_pkg;

  localparam int GRID_W_DEF = 15;
  localparam int GRID_H_DEF = 15;

  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_Z     = 8'h1D;
  localparam logic [7:0] KC_BKSP  = 8'h2A;
  localparam logic [7:0] KC_RIGHT = 8'h4F;
  localparam logic [7:0] KC_LEFT  = 8'h50;
  localparam logic [7:0] KC_DOWN  = 8'h51;
  localparam logic [7:0] KC_UP    = 8'h52;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_A     = 8'h41;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WRITE  = 3'd2,
    ST_MOVE   = 3'd3,
    ST_HOLD   = 3'd4
  } entry_state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_FWD   = 3'd1,
    OP_BACK  = 3'd2,
    OP_RIGHT = 3'd3,
    OP_LEFT  = 3'd4,
    OP_DOWN  = 3'd5,
    OP_UP    = 3'd6
  } move_op_t;

endpackage
`default_nettype wire

// File: rtl/typematic_timer.sv
`default_nettype none
// ============================================================================
// typematic_timer : held-key counter, fires after FIRST cycles then every RATE
// Revision 1.0
// ============================================================================
module typematic_timer #(
  parameter int FIRST = 25_000_000,
  parameter int RATE  = 5_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic clear_i,
  output logic fire_o
);

  // Width sized for FIRST; RATE is expected not to exceed FIRST.
  localparam int CW = $clog2(FIRST + 1);
  localparam logic [CW-1:0] FIRST_M1 = CW'(FIRST - 1);
  localparam logic [CW-1:0] RATE_M1  = CW'(RATE - 1);

  logic [CW-1:0] count_q, count_d;
  logic          first_done_q, first_done_d;

  always_comb begin
    count_d      = count_q;
    first_done_d = first_done_q;
    fire_o       = run_i && !clear_i &&
                   (count_q == (first_done_q ? RATE_M1 : FIRST_M1));
    if (clear_i) begin
      count_d      = '0;
      first_done_d = 1'b0;
    end else if (fire_o) begin
      count_d      = '0;
      first_done_d = 1'b1;
    end else if (run_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q      <= '0;
      first_done_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      first_done_q <= first_done_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/crossword_entry_ctrl.sv
`default_nettype none
// ============================================================================
// crossword_entry_ctrl : keyboard-to-grid entry sequencer with auto-repeat
// Revision 1.0
// ============================================================================
module crossword_entry_ctrl
  import crossword_pkg::*;
#(
  parameter int GRID_W      = GRID_W_DEF,
  parameter int GRID_H      = GRID_H_DEF,
  parameter int ADDR_W      = 8,
  parameter int REPEAT_DLY  = 25_000_000,
  parameter int REPEAT_RATE = 5_000_000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [7:0]        keycode,
  input  logic              move_hl,
  input  logic              start_sw,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ack,
  output logic [3:0]        cursor_x,
  output logic [3:0]        cursor_y,
  output logic              busy
);

  localparam logic [3:0]        X_MAX    = 4'(GRID_W - 1);
  localparam logic [3:0]        Y_MAX    = 4'(GRID_H - 1);
  localparam logic [ADDR_W-1:0] GRID_W_A = ADDR_W'(GRID_W);

  entry_state_t      state_q, state_d;
  move_op_t          op_q, op_d;
  logic [7:0]        key_q, key_d;
  logic              wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [3:0]        cur_x_q, cur_x_d;
  logic [3:0]        cur_y_q, cur_y_d;

  logic              same_key;
  logic              timer_fire;
  logic [ADDR_W-1:0] cell_addr;

  assign same_key  = (keycode == key_q);
  assign cell_addr = ADDR_W'(cur_y_q) * GRID_W_A + ADDR_W'(cur_x_q);

  // The timer keeps counting through DECODE/MOVE so the repeat period is
  // measured from one repeat to the next, not from re-entry into HOLD.
  typematic_timer #(
    .FIRST (REPEAT_DLY),
    .RATE  (REPEAT_RATE)
  ) u_timer (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .run_i   ((state_q != ST_IDLE) && same_key && start_sw),
    .clear_i ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && !same_key)),
    .fire_o  (timer_fire)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    key_d     = key_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    case (state_q)
      ST_IDLE: begin
        if (start_sw && (keycode != 8'h00)) begin
          key_d   = keycode;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_MOVE;
        if ((key_q >= KC_A) && (key_q <= KC_Z)) begin
          wr_data_d = ASCII_A + (key_q - KC_A);
          wr_addr_d = cell_addr;
          wr_req_d  = 1'b1;
          op_d      = OP_FWD;
          state_d   = ST_WRITE;
        end else if (key_q == KC_BKSP) begin
          wr_data_d = ASCII_SPACE;
          wr_addr_d = cell_addr;
          wr_req_d  = 1'b1;
          op_d      = OP_BACK;
          state_d   = ST_WRITE;
        end else if (key_q == KC_RIGHT) op_d = OP_RIGHT;
        else if (key_q == KC_LEFT)  op_d = OP_LEFT;
        else if (key_q == KC_DOWN)  op_d = OP_DOWN;
        else if (key_q == KC_UP)    op_d = OP_UP;
        else                        state_d = ST_HOLD;
      end
      ST_WRITE: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = ST_MOVE;
        end
      end
      ST_MOVE: begin
        state_d = ST_HOLD;
        case (op_q)
          OP_FWD: begin
            if (move_hl) begin
              if (cur_x_q < X_MAX) cur_x_d = cur_x_q + 4'd1;
            end else begin
              if (cur_y_q < Y_MAX) cur_y_d = cur_y_q + 4'd1;
            end
          end
          OP_BACK: begin
            if (move_hl) begin
              if (cur_x_q != 4'd0) cur_x_d = cur_x_q - 4'd1;
            end else begin
              if (cur_y_q != 4'd0) cur_y_d = cur_y_q - 4'd1;
            end
          end
          OP_RIGHT: if (cur_x_q < X_MAX)   cur_x_d = cur_x_q + 4'd1;
          OP_LEFT:  if (cur_x_q != 4'd0)   cur_x_d = cur_x_q - 4'd1;
          OP_DOWN:  if (cur_y_q < Y_MAX)   cur_y_d = cur_y_q + 4'd1;
          OP_UP:    if (cur_y_q != 4'd0)   cur_y_d = cur_y_q - 4'd1;
          default:  ;
        endcase
      end
      ST_HOLD: begin
        if (!same_key)       state_d = ST_IDLE;
        else if (timer_fire) state_d = ST_DECODE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NONE;
      key_q     <= 8'h00;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= ASCII_SPACE;
      cur_x_q   <= 4'd0;
      cur_y_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      key_q     <= key_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
    end
  end

  assign wr_req   = wr_req_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cursor_x = cur_x_q;
  assign cursor_y = cur_y_q;
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_crossword_entry_ctrl.sv
`default_nettype none
// ============================================================================
// tb_crossword_entry_ctrl : directed stimulus with write scoreboard
// Revision 1.0
// ============================================================================
module tb_crossword_entry_ctrl;

  logic       clk_clk       = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic [7:0] keycode       = 8'h00;
  logic       move_hl       = 1'b1;
  logic       start_sw      = 1'b0;
  logic       wr_ack        = 1'b0;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] cursor_x;
  logic [3:0] cursor_y;
  logic       busy;

  crossword_entry_ctrl #(
    .GRID_W      (15),
    .GRID_H      (15),
    .ADDR_W      (8),
    .REPEAT_DLY  (20),
    .REPEAT_RATE (5)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .keycode       (keycode),
    .move_hl       (move_hl),
    .start_sw      (start_sw),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .cursor_x      (cursor_x),
    .cursor_y      (cursor_y),
    .busy          (busy)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks      = 0;
  int  passed      = 0;
  int  writes_seen = 0;
  int  ack_stall   = 0;
  int  stall_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic press(input logic [7:0] kc, input int hold);
    keycode = kc;
    tick(hold);
    keycode = 8'h00;
    tick(4);
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Text-controller model: acknowledges a request after ack_stall idle cycles.
  initial forever begin
    @(posedge clk_clk);
    #1;
    if (wr_ack) begin
      wr_ack = 1'b0;
    end else if (reset_reset_n && wr_req) begin
      if (stall_cnt >= ack_stall) begin
        wr_ack    = 1'b1;
        stall_cnt = 0;
      end else begin
        stall_cnt++;
      end
    end else begin
      stall_cnt = 0;
    end
  end

  // A handshake visible at negedge is taken by the DUT on the next posedge.
  always @(negedge clk_clk) begin
    if (reset_reset_n === 1'b1 && wr_req === 1'b1 && wr_ack === 1'b1) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {24'h0, wr_addr}, {24'h0, e.addr});
        check("wr_data", {24'h0, wr_data}, {24'h0, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic stall_ok;

    // Reset with a key already pressed: no request may escape.
    start_sw = 1'b1;
    keycode  = 8'h04;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_wr_req", wr_req, 0);
    end
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", wr_data, 8'h20);
    check("reset_cursor_x", cursor_x, 0);
    check("reset_cursor_y", cursor_y, 0);
    check("reset_busy", busy, 0);
    keycode       = 8'h00;
    reset_reset_n = 1'b1;
    tick(2);

    // Letter A at (0,0), latency two cycles.
    move_hl = 1'b1;
    expect_write(8'd0, 8'h41);
    keycode = 8'h04;
    tick();
    check("latency_n1_wr_req", wr_req, 0);
    tick();
    check("latency_n2_wr_req", wr_req, 1);
    check("write_busy", busy, 1);
    tick(2);
    keycode = 8'h00;
    tick(4);
    check("letter_cursor_x", cursor_x, 1);
    check("letter_cursor_y", cursor_y, 0);

    // Navigate to (3,14); the last down press is clamped.
    repeat (2) press(8'h4F, 3);
    repeat (15) press(8'h51, 3);
    check("nav1_cursor_x", cursor_x, 3);
    check("nav1_cursor_y", cursor_y, 14);

    move_hl = 1'b0;
    expect_write(8'd213, 8'h5A);
    press(8'h1D, 4);
    check("clamp_cursor_x", cursor_x, 3);
    check("clamp_cursor_y", cursor_y, 14);

    // Navigate to (5,2) and backspace.
    repeat (2) press(8'h4F, 3);
    repeat (12) press(8'h52, 3);
    check("nav2_cursor_x", cursor_x, 5);
    check("nav2_cursor_y", cursor_y, 2);
    move_hl = 1'b1;
    expect_write(8'd35, 8'h20);
    press(8'h2A, 4);
    check("bksp_cursor_x", cursor_x, 4);
    check("bksp_cursor_y", cursor_y, 2);

    // Stalled ack while the key is released.
    ack_stall = 10;
    expect_write(8'd34, 8'h42);
    keycode = 8'h05;
    tick(2);
    keycode  = 8'h00;
    stall_ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (wr_req !== 1'b1 || wr_addr !== 8'd34 || wr_data !== 8'h42 || busy !== 1'b1)
        stall_ok = 1'b0;
      tick();
    end
    check("stall_stable", stall_ok, 1);
    check("stall_req_dropped", wr_req, 0);
    tick(3);
    ack_stall = 0;
    check("stall_idle_busy", busy, 0);
    check("stall_cursor_x", cursor_x, 5);
    check("stall_cursor_y", cursor_y, 2);
    check("writes_after_stall", writes_seen, 4);

    // Unclassified key and disabled entry: no write, no move.
    press(8'h2C, 4);
    check("other_cursor_x", cursor_x, 5);
    start_sw = 1'b0;
    press(8'h06, 4);
    start_sw = 1'b1;
    check("disabled_cursor_x", cursor_x, 5);
    check("disabled_writes", writes_seen, 4);

    // Back to (0,0); the sixth left press is clamped.
    repeat (6) press(8'h50, 3);
    repeat (2) press(8'h52, 3);
    check("home_cursor_x", cursor_x, 0);
    check("home_cursor_y", cursor_y, 0);

    // Typematic repeat: held 40 cycles -> press move plus four repeats.
    keycode = 8'h4F;
    tick(19);
    check("repeat_before_first", cursor_x, 1);
    tick(7);
    check("repeat_first", cursor_x, 2);
    tick(14);
    keycode = 8'h00;
    tick(6);
    check("repeat_final_x", cursor_x, 5);
    check("repeat_final_busy", busy, 0);

    // Reset in the middle of a stalled write.
    ack_stall = 50;
    keycode   = 8'h07;
    tick(2);
    check("midwrite_req", wr_req, 1);
    reset_reset_n = 1'b0;
    tick();
    check("midwrite_reset_req", wr_req, 0);
    check("midwrite_reset_x", cursor_x, 0);
    keycode = 8'h00;
    tick(2);
    reset_reset_n = 1'b1;
    tick(3);
    check("post_reset_req", wr_req, 0);
    check("post_reset_busy", busy, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    check("total_writes", writes_seen, 4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
